// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: base opcodes, the canonical NOP and the
// instruction classes the retirement monitor keeps separate counts for.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_ALU,
        CLS_SYSTEM
    } instr_class_t;

endpackage

// File: rtl/instr_class_decode.sv
// Combinational opcode -> instruction class lookup used by the retirement monitor.
// Opcodes outside the recognised set map to CLS_NONE.
module instr_class_decode
    import riscv_pkg::*;
(
    input  logic [6:0]   opcode,
    output instr_class_t instr_class
);

    always_comb begin
        instr_class = CLS_NONE;
        case (opcode)
            OP_LOAD:                            instr_class = CLS_LOAD;
            OP_STORE:                           instr_class = CLS_STORE;
            OP_BRANCH:                          instr_class = CLS_BRANCH;
            OP_JAL, OP_JALR:                    instr_class = CLS_JUMP;
            OP_OP, OP_IMM, OP_LUI, OP_AUIPC:    instr_class = CLS_ALU;
            OP_SYSTEM:                          instr_class = CLS_SYSTEM;
            default:                            instr_class = CLS_NONE;
        endcase
    end

endmodule

// File: rtl/retire_perf_monitor.sv
// Non-intrusive writeback-stage monitor: cycle, retirement, stall, bubble and
// per-class counters, plus a sticky timeout flag for simulation harnesses.
module retire_perf_monitor
    import riscv_pkg::*;
#(
    parameter int          CNT_WIDTH      = 64,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 valid_w_i,
    input  logic                 stall_w_i,
    input  logic [31:0]          instr_w_i,
    output logic                 retire_o,
    output logic [CNT_WIDTH-1:0] cycle_cnt_o,
    output logic [CNT_WIDTH-1:0] instret_cnt_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o,
    output logic [CNT_WIDTH-1:0] bubble_cnt_o,
    output logic [CNT_WIDTH-1:0] load_cnt_o,
    output logic [CNT_WIDTH-1:0] store_cnt_o,
    output logic [CNT_WIDTH-1:0] branch_cnt_o,
    output logic [CNT_WIDTH-1:0] jump_cnt_o,
    output logic [CNT_WIDTH-1:0] alu_cnt_o,
    output logic [CNT_WIDTH-1:0] system_cnt_o,
    output logic [31:0]          last_instr_o,
    output logic                 timeout_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE       = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);

    instr_class_t instr_class;
    logic         retire;
    logic         bubble;

    instr_class_decode u_decode (
        .opcode      (instr_w_i[6:0]),
        .instr_class (instr_class)
    );

    // Stall wins over valid, so every active cycle is exactly one of retire/stall/bubble.
    assign retire   = valid_w_i & ~stall_w_i;
    assign bubble   = ~valid_w_i & ~stall_w_i;
    assign retire_o = retire & reset_i;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            cycle_cnt_o   <= '0;
            instret_cnt_o <= '0;
            stall_cnt_o   <= '0;
            bubble_cnt_o  <= '0;
            load_cnt_o    <= '0;
            store_cnt_o   <= '0;
            branch_cnt_o  <= '0;
            jump_cnt_o    <= '0;
            alu_cnt_o     <= '0;
            system_cnt_o  <= '0;
            last_instr_o  <= NOP_INSTR;
            timeout_o     <= 1'b0;
        end else begin
            cycle_cnt_o <= cycle_cnt_o + CNT_ONE;

            // Sets on the edge where the count moves from TIMEOUT_CYCLES to TIMEOUT_CYCLES+1.
            if (cycle_cnt_o == TIMEOUT_LIMIT) begin
                timeout_o <= 1'b1;
            end

            if (stall_w_i) begin
                stall_cnt_o <= stall_cnt_o + CNT_ONE;
            end
            if (bubble) begin
                bubble_cnt_o <= bubble_cnt_o + CNT_ONE;
            end

            // instr_w_i is only looked at here, so X on a non-retiring slot never reaches state.
            if (retire) begin
                instret_cnt_o <= instret_cnt_o + CNT_ONE;
                last_instr_o  <= instr_w_i;
                case (instr_class)
                    CLS_LOAD:   load_cnt_o   <= load_cnt_o   + CNT_ONE;
                    CLS_STORE:  store_cnt_o  <= store_cnt_o  + CNT_ONE;
                    CLS_BRANCH: branch_cnt_o <= branch_cnt_o + CNT_ONE;
                    CLS_JUMP:   jump_cnt_o   <= jump_cnt_o   + CNT_ONE;
                    CLS_ALU:    alu_cnt_o    <= alu_cnt_o    + CNT_ONE;
                    CLS_SYSTEM: system_cnt_o <= system_cnt_o + CNT_ONE;
                    default:    ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_retire_perf_monitor.sv
// Scoreboard bench for retire_perf_monitor: each driven cycle pushes the expected
// counter snapshot, which is popped and compared one edge later.
module tb_retire_perf_monitor;

    localparam int CW = 64;

    logic          clk_i;
    logic          reset_i;
    logic          valid_w_i;
    logic          stall_w_i;
    logic [31:0]   instr_w_i;
    logic          retire_o;
    logic [CW-1:0] cycle_cnt_o, instret_cnt_o, stall_cnt_o, bubble_cnt_o;
    logic [CW-1:0] load_cnt_o, store_cnt_o, branch_cnt_o, jump_cnt_o, alu_cnt_o, system_cnt_o;
    logic [31:0]   last_instr_o;
    logic          timeout_o;

    typedef struct {
        logic [63:0] cyc, instret, stl, bub, ld, st, br, jmp, alu, sys;
        logic [31:0] last;
        logic        tmo;
    } snap_t;

    snap_t exp_q[$];
    snap_t model;
    int    checks   = 0;
    int    failures = 0;

    retire_perf_monitor #(.CNT_WIDTH(CW), .TIMEOUT_CYCLES(20)) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .valid_w_i     (valid_w_i),
        .stall_w_i     (stall_w_i),
        .instr_w_i     (instr_w_i),
        .retire_o      (retire_o),
        .cycle_cnt_o   (cycle_cnt_o),
        .instret_cnt_o (instret_cnt_o),
        .stall_cnt_o   (stall_cnt_o),
        .bubble_cnt_o  (bubble_cnt_o),
        .load_cnt_o    (load_cnt_o),
        .store_cnt_o   (store_cnt_o),
        .branch_cnt_o  (branch_cnt_o),
        .jump_cnt_o    (jump_cnt_o),
        .alu_cnt_o     (alu_cnt_o),
        .system_cnt_o  (system_cnt_o),
        .last_instr_o  (last_instr_o),
        .timeout_o     (timeout_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Reference model: classes listed straight from the RV32 base opcode map.
    function automatic snap_t model_step(input snap_t s, input logic rst, input logic v,
                                         input logic stl, input logic [31:0] instr);
        snap_t n = s;
        if (!rst) begin
            n = '{default: '0};
            n.last = 32'h0000_0013;
        end else begin
            if (s.cyc == 64'd20) n.tmo = 1'b1;
            n.cyc++;
            if (stl) n.stl++;
            else if (v) begin
                n.instret++;
                n.last = instr;
                case (instr[6:0])
                    7'h03:                      n.ld++;
                    7'h23:                      n.st++;
                    7'h63:                      n.br++;
                    7'h6F, 7'h67:               n.jmp++;
                    7'h33, 7'h13, 7'h37, 7'h17: n.alu++;
                    7'h73:                      n.sys++;
                    default:                    ;
                endcase
            end else n.bub++;
        end
        return n;
    endfunction

    task automatic apply_stimulus(input logic rst, input logic v, input logic stl, input logic [31:0] instr);
        snap_t e;
        reset_i   = rst;
        valid_w_i = v;
        stall_w_i = stl;
        instr_w_i = (v && !stl) ? instr : 32'hxxxx_xxxx;
        #1;
        check_output("retire_o", {63'd0, retire_o}, {63'd0, rst & v & ~stl});
        model = model_step(model, rst, v, stl, instr);
        exp_q.push_back(model);
        @(posedge clk_i);
        #1;
        if (exp_q.size() == 0) begin
            check_output("scoreboard_empty", 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            check_output("cycle",   cycle_cnt_o,   e.cyc);
            check_output("instret", instret_cnt_o, e.instret);
            check_output("stall",   stall_cnt_o,   e.stl);
            check_output("bubble",  bubble_cnt_o,  e.bub);
            check_output("load",    load_cnt_o,    e.ld);
            check_output("store",   store_cnt_o,   e.st);
            check_output("branch",  branch_cnt_o,  e.br);
            check_output("jump",    jump_cnt_o,    e.jmp);
            check_output("alu",     alu_cnt_o,     e.alu);
            check_output("system",  system_cnt_o,  e.sys);
            check_output("last_instr", {32'd0, last_instr_o}, {32'd0, e.last});
            check_output("timeout", {63'd0, timeout_o}, {63'd0, e.tmo});
        end
    endtask

    initial begin
        logic [31:0] prog [5];
        logic [6:0]  ops [12];
        logic [31:0] r;
        logic [63:0] ld_before;
        prog = '{32'h0050_0093, 32'h0000_A103, 32'h0011_2023, 32'h0000_0063, 32'h0080_00EF};
        ops  = '{7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h33, 7'h13, 7'h37, 7'h17, 7'h73, 7'h7F, 7'h00};
        model     = '{default: '0};
        reset_i   = 1'b0;
        valid_w_i = 1'b0;
        stall_w_i = 1'b0;
        instr_w_i = 32'h0;
        @(posedge clk_i);
        #1;

        $display("[TB] reset then idle");
        repeat (2) apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
        check_output("reset_last", {32'd0, last_instr_o}, 64'h13);
        repeat (10) apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        check_output("idle_cycle",   cycle_cnt_o,   64'd10);
        check_output("idle_bubble",  bubble_cnt_o,  64'd10);
        check_output("idle_instret", instret_cnt_o, 64'd0);

        $display("[TB] one retirement per class");
        foreach (prog[i]) apply_stimulus(1'b1, 1'b1, 1'b0, prog[i]);
        check_output("prog_instret", instret_cnt_o, 64'd5);
        check_output("prog_last", {32'd0, last_instr_o}, 64'h0080_00EF);
        check_output("prog_jump", jump_cnt_o, 64'd1);

        $display("[TB] stalled valid slots");
        repeat (3) apply_stimulus(1'b1, 1'b1, 1'b1, 32'h0000_0013);
        check_output("stall_total", stall_cnt_o, 64'd3);
        check_output("stall_instret", instret_cnt_o, 64'd5);

        $display("[TB] timeout boundary");
        while (cycle_cnt_o < 64'd20) apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        check_output("timeout_at_20", {63'd0, timeout_o}, 64'd0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        check_output("timeout_at_21", {63'd0, timeout_o}, 64'd1);
        repeat (3) apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        check_output("timeout_sticky", {63'd0, timeout_o}, 64'd1);

        $display("[TB] unknown opcode");
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0000_007F);
        check_output("unk_instret", instret_cnt_o, 64'd6);
        check_output("unk_alu", alu_cnt_o, 64'd1);

        $display("[TB] mid-run reset");
        apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0000_0013);
        check_output("rst_cycle", cycle_cnt_o, 64'd0);
        check_output("rst_last", {32'd0, last_instr_o}, 64'h13);
        check_output("rst_timeout", {63'd0, timeout_o}, 64'd0);

        $display("[TB] random traffic");
        ld_before = load_cnt_o;
        for (int i = 0; i < 60; i++) begin
            r = $urandom();
            apply_stimulus(($urandom_range(0, 19) != 0), r[0], (r[2:1] == 2'b11),
                           {r[31:7], ops[$urandom_range(0, 11)]});
        end
        check_output("rand_drained", 64'(exp_q.size()), 64'd0);
        if (ld_before !== 64'd0) check_output("rand_ld_base", ld_before, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
